keystream_responder: RTL and testbench
======================================

// Module: keystream_responder
// PURPOSE
//  Keystream source on the responder side of the hash request interface.
//  - Receives request_byte_pulse from encryption/decryption blocks.
//  - Returns one keystream byte per request: hash_byte plus a 1-cycle hash_byte_pulse.
//  - Publishes hash_generator_state so requesters know when they may request.
//  - Sits beside the data router; the router delivers key bytes here.
// PARAMETERS
//  ROUNDS        8              LFSR steps per output byte (>=1)
//  POLY          32'h8020_0003  Galois LFSR feedback mask
//  SEED_DEFAULT  32'hACE1_2468  state after reset/zeroize; substitute for an all-zero key
// PORTS
//  clk                      in   1   clock
//  nrst                     in   1   asynchronous active-low reset
//  key_byte_in              in   8   key byte, MSB-first order
//  key_byte_pulse           in   1   key_byte_in valid (1 cycle)
//  request_byte_pulse_in    in   1   keystream byte request (1 cycle)
//  hash_byte_out            out  8   keystream byte, held until the next output
//  hash_byte_pulse_out      out  1   hash_byte_out updated (1 cycle)
//  hash_generator_state_out out  hash_generator_state_t  current state
//  zeroize_pulse            in   1   present only with KEYSTREAM_ZEROIZE_EN
// BEHAVIOUR
//  Single clock (clk); asynchronous active-low reset (nrst).
//  Reset values:
//  - state = H_GROUND (encoding '0); lfsr = SEED_DEFAULT.
//  - hash_byte_out = 0; hash_byte_pulse_out = 0.
//  - key_cnt = 0; round_cnt = 0; pending = 0; keyed = 0.
//  States: H_GROUND, H_LOADING, H_BUSY, H_READY.
//  - H_GROUND: unkeyed, default seed, requests accepted.
//  - H_READY: keyed, requests accepted.
//  LFSR step: lsb = s[0]; s = s >> 1; if lsb, s ^= POLY.
//  Request in GROUND/READY:
//  - Sampled at edge E0, then state = H_BUSY.
//  - One step per edge; after ROUNDS steps, hash_byte_out <= s[7:0] and pulse = 1.
//  - Pulse is high in the cycle after edge E0+ROUNDS, i.e. latency = ROUNDS cycles.
//  - On the pulse edge, return to H_READY if keyed, else H_GROUND.
//  Key load:
//  - key_byte_pulse in GROUND/READY -> H_LOADING; s <= {s[23:0], key_byte_in}; key_cnt = 1.
//  - Each further pulse shifts one byte in. The 4th byte completes the key: keyed = 1, state = H_READY.
//  - If the completed key is all-zero, load SEED_DEFAULT instead. LFSR state is never 0.
//  Request during H_BUSY or H_LOADING:
//  - Sets pending; only one is held, and further requests are dropped.
//  - Pending is served when the FSM returns to GROUND/READY. It goes straight to H_BUSY on that edge, with no idle cycle.
//  key_byte_pulse during H_BUSY: byte dropped.
//  Request and key_byte_pulse in the same cycle (GROUND/READY): request wins, key byte dropped.
//  Request while pulse out is high: accepted normally.
//  hash_byte_out must stay stable after the pulse; requesters XOR it in the following cycle.
//  Reset mid-operation: all registers return to reset values immediately. A partial key and any pending request are lost.
// CONFIGURATION
//  KEYSTREAM_ZEROIZE_EN defined:
//  - Adds the zeroize_pulse input, which has priority over everything.
//  - Next edge: state = H_GROUND, s = SEED_DEFAULT.
//  - keyed, pending and key_cnt are cleared; an in-flight byte is abandoned with no pulse.
//  - hash_byte_out is cleared to 0.
//  KEYSTREAM_ZEROIZE_EN undefined: no port; a key is cleared only by nrst or a new full key load.
// TESTING
//  1. Reset -> state H_GROUND, hash_byte_out 0x00, pulse 0, for at least 3 cycles with no input.
//  2. ROUNDS=1, all-zero key (00,00,00,00) -> H_READY. Request -> 0x34 (s=0x5670_9234), 1 cycle later.
//  3. ROUNDS=1, key 00,00,00,02, then request twice -> 0x01, then 0x03 (s=0x8020_0003).
//  4. Defaults: request, then a second request 2 cycles later -> second pulse exactly 8 cycles after the first.
//     A third request while pending is full -> dropped.
//  5. Request and key_byte_pulse in the same cycle -> H_BUSY, key_cnt stays 0.
//     Assert nrst mid-H_BUSY -> no pulse, state H_GROUND.
//  6. KEYSTREAM_ZEROIZE_EN: key loaded, zeroize during H_BUSY -> no pulse, H_GROUND.
//     Next request with ROUNDS=1 -> 0x34.

Source files
------------

// File: rtl/keystream_responder.sv
// Keystream byte source: an LFSR keyed over a byte interface, answering one-cycle
// requests with one byte each. Optional zeroize port enabled by KEYSTREAM_ZEROIZE_EN.
module keystream_responder #(
    parameter int          ROUNDS       = 8,
    parameter logic [31:0] POLY         = 32'h8020_0003,
    parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] key_byte_in,
    input  logic       key_byte_pulse,
    input  logic       request_byte_pulse_in,
`ifdef KEYSTREAM_ZEROIZE_EN
    input  logic       zeroize_pulse,
`endif
    output logic [7:0] hash_byte_out,
    output logic       hash_byte_pulse_out,
    output logic [1:0] hash_generator_state_out
);

    typedef enum logic [1:0] {
        H_GROUND  = 2'd0,
        H_LOADING = 2'd1,
        H_BUSY    = 2'd2,
        H_READY   = 2'd3
    } hash_generator_state_t;

    localparam int RC_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RC_W-1:0] LAST_ROUND = RC_W'(ROUNDS - 1);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    hash_generator_state_t state_q, state_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [7:0]      hash_q, hash_d;
    logic            pulse_q, pulse_d;
    logic [1:0]      key_cnt_q, key_cnt_d;
    logic [RC_W-1:0] round_cnt_q, round_cnt_d;
    logic            pending_q, pending_d;
    logic            keyed_q, keyed_d;
    logic [31:0]     shifted;
    logic [31:0]     lfsr_next;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        hash_d      = hash_q;
        pulse_d     = 1'b0;
        key_cnt_d   = key_cnt_q;
        round_cnt_d = round_cnt_q;
        pending_d   = pending_q;
        keyed_d     = keyed_q;
        shifted     = {lfsr_q[23:0], key_byte_in};
        lfsr_next   = lfsr_step(lfsr_q);

        case (state_q)
            H_GROUND, H_READY: begin
                // A request beats a key byte arriving in the same cycle.
                if (request_byte_pulse_in) begin
                    state_d     = H_BUSY;
                    round_cnt_d = '0;
                end else if (key_byte_pulse) begin
                    state_d   = H_LOADING;
                    lfsr_d    = shifted;
                    key_cnt_d = 2'd1;
                end
            end
            H_LOADING: begin
                if (request_byte_pulse_in) pending_d = 1'b1;
                if (key_byte_pulse) begin
                    lfsr_d = shifted;
                    if (key_cnt_q == 2'd3) begin
                        key_cnt_d = 2'd0;
                        keyed_d   = 1'b1;
                        if (shifted == 32'd0) lfsr_d = SEED_DEFAULT;
                        if (pending_q || request_byte_pulse_in) begin
                            state_d     = H_BUSY;
                            round_cnt_d = '0;
                            pending_d   = 1'b0;
                        end else begin
                            state_d = H_READY;
                        end
                    end else begin
                        key_cnt_d = key_cnt_q + 2'd1;
                    end
                end
            end
            H_BUSY: begin
                lfsr_d = lfsr_next;
                if (round_cnt_q == LAST_ROUND) begin
                    hash_d      = lfsr_next[7:0];
                    pulse_d     = 1'b1;
                    round_cnt_d = '0;
                    // A held (or just-arrived) request restarts with no idle cycle.
                    if (pending_q || request_byte_pulse_in) begin
                        state_d   = H_BUSY;
                        pending_d = 1'b0;
                    end else begin
                        state_d = keyed_q ? H_READY : H_GROUND;
                    end
                end else begin
                    round_cnt_d = round_cnt_q + 1'b1;
                    if (request_byte_pulse_in) pending_d = 1'b1;
                end
            end
            default: state_d = H_GROUND;
        endcase

`ifdef KEYSTREAM_ZEROIZE_EN
        if (zeroize_pulse) begin
            state_d     = H_GROUND;
            lfsr_d      = SEED_DEFAULT;
            hash_d      = 8'd0;
            pulse_d     = 1'b0;
            key_cnt_d   = 2'd0;
            round_cnt_d = '0;
            pending_d   = 1'b0;
            keyed_d     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= H_GROUND;
            lfsr_q      <= SEED_DEFAULT;
            hash_q      <= 8'd0;
            pulse_q     <= 1'b0;
            key_cnt_q   <= 2'd0;
            round_cnt_q <= '0;
            pending_q   <= 1'b0;
            keyed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            hash_q      <= hash_d;
            pulse_q     <= pulse_d;
            key_cnt_q   <= key_cnt_d;
            round_cnt_q <= round_cnt_d;
            pending_q   <= pending_d;
            keyed_q     <= keyed_d;
        end
    end

    assign hash_byte_out            = hash_q;
    assign hash_byte_pulse_out      = pulse_q;
    assign hash_generator_state_out = state_q;

endmodule

// File: tb/tb_keystream_responder.sv
// Bench for keystream_responder: a ROUNDS=1 and a default instance driven by directed
// and random steps, checked against a word-level keystream model.
module tb_keystream_responder;

    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam logic [1:0]  S_GROUND = 2'd0, S_LOADING = 2'd1, S_BUSY = 2'd2, S_READY = 2'd3;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] k1 = 8'd0, k8 = 8'd0;
    logic       kp1 = 1'b0, kp8 = 1'b0, rq1 = 1'b0, rq8 = 1'b0;
    logic       zp = 1'b0;
    logic [7:0] h1, h8;
    logic       p1, p8;
    logic [1:0] st1, st8;

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    int pcyc[$];
    logic [7:0] pval[$];

    // Model: LFSR state and keyed flag per instance.
    logic [31:0] m1 = SEED, m8 = SEED;
    logic        kd1 = 1'b0, kd8 = 1'b0;

    always #5 clk = ~clk;

    keystream_responder #(.ROUNDS(1)) dut1 (
`ifdef KEYSTREAM_ZEROIZE_EN
        .zeroize_pulse(zp),
`endif
        .clk(clk), .nrst(nrst), .key_byte_in(k1), .key_byte_pulse(kp1),
        .request_byte_pulse_in(rq1), .hash_byte_out(h1), .hash_byte_pulse_out(p1),
        .hash_generator_state_out(st1)
    );

    keystream_responder dut8 (
`ifdef KEYSTREAM_ZEROIZE_EN
        .zeroize_pulse(zp),
`endif
        .clk(clk), .nrst(nrst), .key_byte_in(k8), .key_byte_pulse(kp8),
        .request_byte_pulse_in(rq8), .hash_byte_out(h8), .hash_byte_pulse_out(p8),
        .hash_generator_state_out(st8)
    );

    function automatic logic [31:0] lfsr_run(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (p8 === 1'b1) begin
            pcyc.push_back(cyc);
            pval.push_back(h8);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input int which, input logic [31:0] key);
        for (int i = 0; i < 4; i++) begin
            if (which == 1) begin k1 = key[31-8*i -: 8]; kp1 = 1'b1; end
            else            begin k8 = key[31-8*i -: 8]; kp8 = 1'b1; end
            tick();
            kp1 = 1'b0;
            kp8 = 1'b0;
        end
        if (which == 1) begin m1 = (key == 0) ? SEED : key; kd1 = 1'b1; end
        else            begin m8 = (key == 0) ? SEED : key; kd8 = 1'b1; end
    endtask

    task automatic do_req(input int which, input string tag);
        logic [31:0] ms, nxt;
        logic [7:0]  val;
        logic [1:0]  st;
        logic        done;
        int          rounds, lat;
        logic        kd;
        ms     = (which == 1) ? m1 : m8;
        kd     = (which == 1) ? kd1 : kd8;
        rounds = (which == 1) ? 1 : 8;
        nxt    = lfsr_run(ms, rounds);
        if (which == 1) rq1 = 1'b1; else rq8 = 1'b1;
        tick();
        rq1 = 1'b0;
        rq8 = 1'b0;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 64) begin
            tick();
            lat++;
            done = (which == 1) ? p1 : p8;
        end
        val = (which == 1) ? h1 : h8;
        st  = (which == 1) ? st1 : st8;
        check({tag, "_byte"}, val, nxt[7:0]);
        check({tag, "_latency"}, lat, rounds);
        check({tag, "_state"}, st, kd ? S_READY : S_GROUND);
        tick();
        check({tag, "_pulse_1cyc"}, (which == 1) ? p1 : p8, 1'b0);
        check({tag, "_hold"}, (which == 1) ? h1 : h8, nxt[7:0]);
        if (which == 1) m1 = nxt; else m8 = nxt;
    endtask

    initial begin
        logic [31:0] key;
        int c_e0, d;

        // Reset behaviour
        repeat (3) tick();
        check("rst_state8", st8, S_GROUND);
        check("rst_hash8", h8, 8'h00);
        check("rst_pulse8", p8, 1'b0);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_state8", st8, S_GROUND);
            check("idle_state1", st1, S_GROUND);
            check("idle_hash8", h8, 8'h00);
            check("idle_pulse8", p8, 1'b0);
        end

        // All-zero key falls back to the seed
        load_key(1, 32'h0);
        check("zero_key_ready", st1, S_READY);
        check("zero_key_spec", lfsr_run(m1, 1), 32'h5670_9234);
        do_req(1, "zero_key_req");
        check("zero_key_const", h1, 8'h34);

        // Small key, two requests
        load_key(1, 32'h0000_0002);
        do_req(1, "key2_req_a");
        check("key2_const_a", h1, 8'h01);
        do_req(1, "key2_req_b");
        check("key2_const_b", h1, 8'h03);

        // Pending request, third request dropped
        pcyc.delete();
        pval.delete();
        rq8 = 1'b1;
        tick();
        c_e0 = cyc;
        rq8 = 1'b0;
        tick();
        rq8 = 1'b1;
        tick();
        rq8 = 1'b1;
        tick();
        rq8 = 1'b0;
        repeat (40) tick();
        check("pend_pulse_count", pcyc.size(), 2);
        d = (pcyc.size() >= 2) ? pcyc[1] - pcyc[0] : -1;
        check("pend_spacing", d, 8);
        d = (pcyc.size() >= 1) ? pcyc[0] - c_e0 : -1;
        check("pend_first_latency", d, 8);
        key = lfsr_run(SEED, 8);
        check("pend_byte_a", (pval.size() >= 1) ? pval[0] : 8'hxx, key[7:0]);
        key = lfsr_run(SEED, 16);
        check("pend_byte_b", (pval.size() >= 2) ? pval[1] : 8'hxx, key[7:0]);
        check("pend_end_state", st8, S_GROUND);
        m8 = key;

        // Request and key byte together: request wins, byte lost
        k8 = 8'($urandom);
        kp8 = 1'b1;
        rq8 = 1'b1;
        tick();
        kp8 = 1'b0;
        rq8 = 1'b0;
        check("collide_busy", st8, S_BUSY);
        repeat (10) tick();
        m8 = lfsr_run(m8, 8);
        check("collide_back", st8, S_GROUND);
        key = $urandom;
        for (int i = 0; i < 4; i++) begin
            k8 = key[31-8*i -: 8];
            kp8 = 1'b1;
            tick();
            kp8 = 1'b0;
            if (i == 2) check("collide_key3_loading", st8, S_LOADING);
        end
        check("collide_key4_ready", st8, S_READY);
        m8 = (key == 0) ? SEED : key;
        kd8 = 1'b1;
        do_req(8, "collide_keyed_req");

        // Reset mid-busy
        rq8 = 1'b1;
        tick();
        rq8 = 1'b0;
        repeat (3) tick();
        nrst = 1'b0;
        #1;
        check("midrst_state", st8, S_GROUND);
        check("midrst_pulse", p8, 1'b0);
        check("midrst_hash", h8, 8'h00);
        tick();
        nrst = 1'b1;
        pcyc.delete();
        repeat (12) tick();
        check("midrst_no_pulse", pcyc.size(), 0);
        m1 = SEED; m8 = SEED; kd1 = 1'b0; kd8 = 1'b0;

        // Random keys and requests on both instances
        for (int it = 0; it < 24; it++) begin
            int which;
            which = ($urandom_range(0, 1) == 0) ? 1 : 8;
            if ($urandom_range(0, 2) == 0) begin
                key = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                load_key(which, key);
                check("rand_key_ready", (which == 1) ? st1 : st8, S_READY);
            end else begin
                do_req(which, "rand_req");
            end
        end

`ifdef KEYSTREAM_ZEROIZE_EN
        // Zeroize in flight
        load_key(8, $urandom | 32'h1);
        rq8 = 1'b1;
        tick();
        rq8 = 1'b0;
        repeat (2) tick();
        zp = 1'b1;
        pcyc.delete();
        tick();
        zp = 1'b0;
        check("zero_state8", st8, S_GROUND);
        check("zero_state1", st1, S_GROUND);
        check("zero_hash8", h8, 8'h00);
        check("zero_hash1", h1, 8'h00);
        check("zero_pulse8", p8, 1'b0);
        repeat (10) tick();
        check("zero_no_pulse", pcyc.size(), 0);
        m1 = SEED; m8 = SEED; kd1 = 1'b0; kd8 = 1'b0;
        do_req(1, "zero_after_req");
        check("zero_after_const", h1, 8'h34);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
